// File: rtl/mult_share_arbiter.sv
// ============================================================================
// Module   : mult_share_arbiter
// Purpose  : Round-robin sharing of one sequential multiplier between two
//            requesters; issues the operands, waits the fixed multiplier
//            latency and returns the product to the granted requester.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_share_arbiter #(
   parameter int WIDTH        = 4,
   parameter int MULT_LATENCY = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req0_i,
   input  logic [WIDTH-1:0]   a0_i,
   input  logic [WIDTH-1:0]   b0_i,
   output logic               ack0_o,
   output logic               res0_valid_o,
   output logic [2*WIDTH-1:0] res0_o,
   input  logic               req1_i,
   input  logic [WIDTH-1:0]   a1_i,
   input  logic [WIDTH-1:0]   b1_i,
   output logic               ack1_o,
   output logic               res1_valid_o,
   output logic [2*WIDTH-1:0] res1_o,
   output logic               mult_en_o,
   output logic [WIDTH-1:0]   mult_a_o,
   output logic [WIDTH-1:0]   mult_b_o,
   input  logic [2*WIDTH-1:0] mult_y_i,
   output logic               busy_o,
   output logic               grant_o,
   output logic [1:0]         fsm_state_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int              CNT_W     = $clog2(MULT_LATENCY + 1);
   localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MULT_LATENCY);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_grant;
   logic               r_last_grant;
   logic [WIDTH-1:0]   r_mult_a;
   logic [WIDTH-1:0]   r_mult_b;
   logic [2*WIDTH-1:0] r_res0;
   logic [2*WIDTH-1:0] r_res1;
   logic               w_winner;

   // A lone request always wins; a tie goes to whoever was not served last.
   always_comb begin
      w_winner = req1_i;
      if (req0_i && req1_i) begin
         w_winner = ~r_last_grant;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_mult_a     <= '0;
         r_mult_b     <= '0;
         r_res0       <= '0;
         r_res1       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req0_i || req1_i) begin
                  r_grant  <= w_winner;
                  r_mult_a <= w_winner ? a1_i : a0_i;
                  r_mult_b <= w_winner ? b1_i : b0_i;
                  r_state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= c_CNT_LOAD;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_cnt <= r_cnt - c_CNT_ONE;
               if (r_cnt == c_CNT_ONE) begin
                  if (r_grant) begin
                     r_res1 <= mult_y_i;
                  end else begin
                     r_res0 <= mult_y_i;
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_last_grant <= r_grant;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Every output is a register or a decode of the state register.
   assign ack0_o       = (r_state == S_ISSUE) && !r_grant;
   assign ack1_o       = (r_state == S_ISSUE) &&  r_grant;
   assign res0_valid_o = (r_state == S_DONE)  && !r_grant;
   assign res1_valid_o = (r_state == S_DONE)  &&  r_grant;
   assign mult_en_o    = (r_state == S_ISSUE);
   assign busy_o       = (r_state != S_IDLE);
   assign fsm_state_o  = r_state;
   assign grant_o      = r_grant;
   assign mult_a_o     = r_mult_a;
   assign mult_b_o     = r_mult_b;
   assign res0_o       = r_res0;
   assign res1_o       = r_res1;

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
// ============================================================================
// Module   : tb_mult_share_arbiter
// Purpose  : Randomised two-requester stimulus against a cycle-stamped
//            transaction model of the shared-multiplier arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_share_arbiter;

   localparam int W = 4;
   localparam int L = 5;

   logic         clk;
   logic         rst;
   logic         req0, req1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         ack0, ack1, val0, val1, mult_en, busy, grant;
   logic [2*W-1:0] res0, res1, mult_y;
   logic [W-1:0] mult_a, mult_b;
   logic [1:0]   fsm_state;

   mult_share_arbiter #(.WIDTH(W), .MULT_LATENCY(L)) dut (
      .clk_i(clk), .rst_i(rst),
      .req0_i(req0), .a0_i(a0), .b0_i(b0),
      .ack0_o(ack0), .res0_valid_o(val0), .res0_o(res0),
      .req1_i(req1), .a1_i(a1), .b1_i(b1),
      .ack1_o(ack1), .res1_valid_o(val1), .res1_o(res1),
      .mult_en_o(mult_en), .mult_a_o(mult_a), .mult_b_o(mult_b),
      .mult_y_i(mult_y), .busy_o(busy), .grant_o(grant),
      .fsm_state_o(fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External multiplier: product is good only once L edges have sampled mult_en.
   logic [3:0]     m_cnt;
   logic           m_loaded;
   logic [2*W-1:0] m_p;
   always @(posedge clk) begin
      if (rst) begin
         m_cnt <= '0; m_loaded <= 1'b0; m_p <= '0;
      end else if (mult_en) begin
         m_cnt <= 4'(L); m_loaded <= 1'b1; m_p <= (2*W)'(mult_a) * (2*W)'(mult_b);
      end else if (m_cnt > 4'd1) begin
         m_cnt <= m_cnt - 4'd1;
      end
   end
   assign mult_y = (m_loaded && m_cnt == 4'd1) ? m_p : ~m_p;

   typedef struct {
      int             c;
      bit             w;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
   } ev_t;
   ev_t q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int free_at = 0;
   int rst_edge = -1;
   bit last_w = 1'b1;

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // Transaction model: one service takes L+3 edges from a sampling edge to the next.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            q.delete();
            free_at  = cyc + 1;
            last_w   = 1'b1;
            rst_edge = cyc;
         end else if (cyc >= free_at && (req0 || req1)) begin
            ev_t e;
            e.w = (req0 && req1) ? !last_w : req1;
            e.c = cyc;
            e.a = e.w ? a1 : a0;
            e.b = e.w ? b1 : b0;
            e.p = (2*W)'(int'(e.a) * int'(e.b));
            q.push_back(e);
            last_w  = e.w;
            free_at = cyc + L + 3;
         end
      end
   end

   // Monitor: expected outputs follow from the head transaction's age.
   logic           m_grant;
   logic [W-1:0]   m_a, m_b;
   logic [2*W-1:0] m_res0, m_res1;
   initial begin
      m_grant = 0; m_a = 0; m_b = 0; m_res0 = 0; m_res1 = 0;
      forever begin
         logic [1:0] e_st;
         logic e_ack0, e_ack1, e_v0, e_v1;
         @(negedge clk);
         if (cyc > 0) begin
            if (rst_edge == cyc) begin
               m_grant = 0; m_a = 0; m_b = 0; m_res0 = 0; m_res1 = 0;
            end
            e_st = 2'd0; e_ack0 = 0; e_ack1 = 0; e_v0 = 0; e_v1 = 0;
            if (q.size() > 0 && q[0].c <= cyc) begin
               int d;
               d = cyc - q[0].c;
               m_grant = q[0].w; m_a = q[0].a; m_b = q[0].b;
               if (d == 0) begin
                  e_st = 2'd1; e_ack0 = !q[0].w; e_ack1 = q[0].w;
               end else if (d <= L) begin
                  e_st = 2'd2;
               end else begin
                  e_st = 2'd3; e_v0 = !q[0].w; e_v1 = q[0].w;
                  if (q[0].w) m_res1 = q[0].p; else m_res0 = q[0].p;
                  q.delete(0);
               end
            end
            cmp("fsm_state", 8'(fsm_state), 8'(e_st));
            cmp("ack0", 8'(ack0), 8'(e_ack0));
            cmp("ack1", 8'(ack1), 8'(e_ack1));
            cmp("mult_en", 8'(mult_en), 8'(e_st == 2'd1));
            cmp("busy", 8'(busy), 8'(e_st != 2'd0));
            cmp("res0_valid", 8'(val0), 8'(e_v0));
            cmp("res1_valid", 8'(val1), 8'(e_v1));
            cmp("grant", 8'(grant), 8'(m_grant));
            cmp("mult_a", 8'(mult_a), 8'(m_a));
            cmp("mult_b", 8'(mult_b), 8'(m_b));
            cmp("res0", res0, m_res0);
            cmp("res1", res1, m_res1);
         end
      end
   end

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         default: return W'($urandom_range(0, 15));
      endcase
   endfunction

   // Requesters: hold req until ack, sometimes re-request at once, sometimes withdraw.
   initial begin
      bit         rq[2];
      int         dly[2];
      int         rst_cnt;
      logic       ack_k;
      logic [W-1:0] av[2], bv[2];
      rst = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      rst_cnt = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rq[0] = 1; av[0] = 4'd15; bv[0] = 4'd15;
      rq[1] = 1; av[1] = 4'd2;  bv[1] = 4'd7;
      dly[0] = 0; dly[1] = 0;
      req0 = 1; a0 = 15; b0 = 15; req1 = 1; a1 = 2; b1 = 7;
      for (int t = 0; t < 4000; t++) begin
         @(negedge clk);
         if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) rst = 1'b0;
         end else if (t > 40 && $urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            rst_cnt = $urandom_range(1, 2);
         end
         for (int k = 0; k < 2; k++) begin
            ack_k = (k == 1) ? ack1 : ack0;
            if (rq[k]) begin
               if (ack_k) begin
                  if ($urandom_range(0, 3) != 0) begin
                     rq[k] = 0;
                     dly[k] = $urandom_range(0, 12);
                  end
               end else if (t > 100 && $urandom_range(0, 39) == 0) begin
                  rq[k] = 0;
                  dly[k] = $urandom_range(0, 6);
               end
            end else if (dly[k] > 0) begin
               dly[k]--;
            end else begin
               rq[k] = 1;
               av[k] = pick_operand();
               bv[k] = pick_operand();
            end
         end
         req0 = rq[0]; a0 = av[0]; b0 = bv[0];
         req1 = rq[1]; a1 = av[1]; b1 = bv[1];
      end
      req0 = 0; req1 = 0; rst = 0;
      repeat (L + 6) @(negedge clk);
      cmp("drain", 8'(q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
